game_ctl: RTL
=============

// Module: game_ctl
// PURPOSE
//  Round/match sequencer for the PONG datapath. Holds the ball controller at centre, releases it after
//  a serve countdown, and detects a miss from ball xpos crossing the court edges. On a miss it scores
//  the point, freezes play, then re-serves toward the player who lost the point.
//  Sits between the top level (buttons, vsync-derived frame tick) and ball_ctl (drives its hold/enable).
// PARAMETERS
//  LEFT_LIMIT    11'd16   xpos <= this in PLAY = left player missed (right scores)
//  RIGHT_LIMIT   11'd1000 xpos >= this in PLAY = right player missed (left scores)
//  SERVE_FRAMES  60       frame ticks spent in SERVE before release (legal range >= 1)
//  POINT_FRAMES  90       frame ticks spent in POINT freeze (legal range >= 1)
//  WIN_SCORE     7        first score equal to this ends the match (legal range 1..2**SCORE_W-1)
//  SCORE_W       4        score counter width
// PORTS
//  clk          in   1        system clock (pixel clock domain)
//  rst          in   1        synchronous reset, active-low
//  frame_tick   in   1        1-cycle pulse per video frame
//  start        in   1        start/restart button, level, already debounced
//  pause        in   1        level; freezes play while high
//  ball_xpos    in   11       ball x position from ball_ctl
//  ball_hold    out  1        1 = ball_ctl held at centre (feeds ball_ctl reset)
//  ball_en      out  1        1 = ball_ctl may advance
//  serve_dir    out  1        0 = serve toward left player, 1 = toward right player
//  score_l      out  SCORE_W  left player score
//  score_r      out  SCORE_W  right player score
//  point_pulse  out  1        1-cycle pulse when a point is scored
//  game_over    out  1        high in GAME_OVER
//  winner       out  1        0 = left won, 1 = right won; valid while game_over = 1
// BEHAVIOUR
//  All outputs registered. Reset (rst = 0 at posedge): state IDLE, both scores 0, ball_hold = 1,
//   ball_en = 0, serve_dir = 1, point_pulse = 0, game_over = 0, winner = 0, frame counter = 0,
//   start edge-detect register = 1 (a start held through reset does not count as a press).
//   Reset mid-round behaves identically.
//  Start press = start rising edge (internal one-register edge detect).
//  States:
//  - IDLE: on a start press -> SERVE, clear both scores, load counter = SERVE_FRAMES.
//  - SERVE: ball_hold = 1, ball_en = 0. Each frame_tick decrements the counter. The tick that takes
//     the counter from 1 to 0 -> PLAY. Dwell is therefore exactly SERVE_FRAMES ticks.
//  - PLAY: ball_hold = 0, ball_en = !pause. The miss check runs only while pause = 0, and the left check
//     has priority. If ball_xpos <= LEFT_LIMIT: score_r+1, serve_dir = 0. Else if ball_xpos >= RIGHT_LIMIT:
//     score_l+1, serve_dir = 1. A hit causes point_pulse = 1 for one cycle, -> POINT, and loads
//     counter = POINT_FRAMES. Score, state and pulse all update on the same edge.
//  - POINT: ball_hold = 0, ball_en = 0 (the ball stays visible at the miss position). Countdown works as in SERVE.
//     At expiry: if score_l == WIN_SCORE or score_r == WIN_SCORE -> GAME_OVER, and winner = (score_r == WIN_SCORE).
//     Otherwise -> SERVE with the counter reloaded.
//  - GAME_OVER: ball_hold = 1, ball_en = 0, game_over = 1, scores frozen. A start press -> IDLE.
//     The same press does not also start a match; a second press is required.
//  pause is ignored outside PLAY. frame_tick is ignored in IDLE, PLAY and GAME_OVER. Scores never wrap,
//   because WIN_SCORE < 2**SCORE_W. ball_xpos is compared unsigned.
// STRUCTURE
//  pong_pkg: game_state_t enum {IDLE, SERVE, PLAY, POINT, GAME_OVER}, and the shared screen constants
//   (HOR_PIXELS = 1024, VER_PIXELS = 768, BALL_SIZE) reused by ball_ctl and the paddle logic.
//  One sub-module, frame_timer: loadable down-counter with load value, load strobe, tick input and
//   1-cycle done output. It is instantiated once and shared by SERVE and POINT.
//  The remaining logic is the FSM plus score registers in game_ctl.
// TESTING
//  1 Reset, then start press -> SERVE. ball_hold stays 1 for exactly 60 frame_ticks, then PLAY with ball_en = 1.
//  2 PLAY, xpos stepped to 16 -> next edge: score_r = 1, point_pulse for 1 cycle, serve_dir = 0, POINT.
//     After 90 ticks -> SERVE.
//  3 PLAY with pause = 1 and xpos = 1000 -> ball_en = 0, no score.
//     Release pause -> score_l = 1 on the next edge.
//  4 Run the score to 6:0, then a right-edge miss -> score_l = 7. After the POINT dwell: game_over = 1,
//     winner = 0. Press -> IDLE. Press again -> SERVE with scores 0:0.
//  5 Reset asserted mid-PLAY and mid-POINT with start held high -> all reset values. No restart until start
//     is released and pressed again.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared PONG types and screen geometry used by the game sequencer, ball_ctl and paddle logic.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    POINT,
    GAME_OVER
  } game_state_t;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;
  localparam int BALL_SIZE  = 16;

endpackage

// File: rtl/frame_timer.sv
// Loadable frame-tick down-counter; done marks the tick that takes the count from 1 to 0.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         done
);

  logic [W-1:0] count_reg;

  // Combinational so the owner can change state on the same edge as the final tick.
  assign done = tick && (count_reg == W'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (tick && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/game_ctl.sv
// PONG round/match sequencer: serve countdown, miss detection, scoring, point freeze, game over.
module game_ctl
  import pong_pkg::*;
#(
  parameter logic [10:0] LEFT_LIMIT   = 11'd16,
  parameter logic [10:0] RIGHT_LIMIT  = 11'd1000,
  parameter int          SERVE_FRAMES = 60,
  parameter int          POINT_FRAMES = 90,
  parameter int          WIN_SCORE    = 7,
  parameter int          SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               pause,
  input  logic [10:0]        ball_xpos,
  output logic               ball_hold,
  output logic               ball_en,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               point_pulse,
  output logic               game_over,
  output logic               winner
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int TIMER_W    = $clog2(MAX_FRAMES + 1);

  game_state_t        state, state_next;
  logic               start_q;
  logic               press;
  logic               miss_l, miss_r;
  logic               win;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timer_tick;
  logic               timer_done;

  assign press      = start && !start_q;
  assign miss_l     = (state == PLAY) && !pause && (ball_xpos <= LEFT_LIMIT);
  assign miss_r     = (state == PLAY) && !pause && !miss_l && (ball_xpos >= RIGHT_LIMIT);
  assign win        = (score_l == SCORE_W'(WIN_SCORE)) || (score_r == SCORE_W'(WIN_SCORE));
  assign timer_tick = frame_tick && ((state == SERVE) || (state == POINT));

  frame_timer #(
    .W(TIMER_W)
  ) u_frame_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .tick     (timer_tick),
    .done     (timer_done)
  );

  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_val  = TIMER_W'(SERVE_FRAMES);
    case (state)
      IDLE: begin
        if (press) begin
          state_next = SERVE;
          timer_load = 1'b1;
        end
      end
      SERVE: begin
        if (timer_done) state_next = PLAY;
      end
      PLAY: begin
        if (miss_l || miss_r) begin
          state_next = POINT;
          timer_load = 1'b1;
          timer_val  = TIMER_W'(POINT_FRAMES);
        end
      end
      POINT: begin
        if (timer_done) begin
          if (win) begin
            state_next = GAME_OVER;
          end else begin
            state_next = SERVE;
            timer_load = 1'b1;
          end
        end
      end
      GAME_OVER: begin
        if (press) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      start_q     <= 1'b1;
      score_l     <= '0;
      score_r     <= '0;
      ball_hold   <= 1'b1;
      ball_en     <= 1'b0;
      serve_dir   <= 1'b1;
      point_pulse <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      state       <= state_next;
      start_q     <= start;
      point_pulse <= miss_l || miss_r;
      ball_hold   <= (state_next == IDLE) || (state_next == SERVE) || (state_next == GAME_OVER);
      ball_en     <= (state_next == PLAY) && !pause;
      game_over   <= (state_next == GAME_OVER);
      if ((state == IDLE) && press) begin
        score_l <= '0;
        score_r <= '0;
      end
      if (miss_l) begin
        score_r   <= score_r + 1'b1;
        serve_dir <= 1'b0;
      end
      if (miss_r) begin
        score_l   <= score_l + 1'b1;
        serve_dir <= 1'b1;
      end
      if ((state == POINT) && timer_done && win) begin
        winner <= (score_r == SCORE_W'(WIN_SCORE));
      end
    end
  end

endmodule
